// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: datapath width, sequential step and fetch FSM encoding.
package inst_fetch_pkg;

    localparam int DATA_WID   = 32;
    localparam int INST_B_DEF = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_skid_buf.sv
// One-entry holding register for an instruction accepted while IF/ID is held.
module inst_fetch_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_predict,
    input  logic [DATA_W-1:0] in_predict_pc,
    output logic              valid,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] pc,
    output logic              predict,
    output logic [DATA_W-1:0] predict_pc
);

    // Flush wins over push so a redirect never leaves a squashed-path entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            inst       <= '0;
            pc         <= '0;
            predict    <= 1'b0;
            predict_pc <= '0;
        end else if (flush) begin
            valid      <= 1'b0;
            inst       <= '0;
            pc         <= '0;
            predict    <= 1'b0;
            predict_pc <= '0;
        end else if (push) begin
            valid      <= 1'b1;
            inst       <= in_inst;
            pc         <= in_pc;
            predict    <= in_predict;
            predict_pc <= in_predict_pc;
        end else if (pop) begin
            valid      <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues icache requests and presents {inst, pc, predict, predict_pc} to IF/ID.
//   state | meaning
//   FETCH | request at pc_q; a same-cycle response is accepted, otherwise go wait
//   WAIT  | miss outstanding, address held until the response returns
//   DROP  | redirected during a miss; swallow the stale response, then fetch at new pc_q
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                DATA_W   = DATA_WID,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] INST_B   = DATA_W'(INST_B_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ic_req,
    output logic [DATA_W-1:0] ic_addr,
    input  logic              ic_resp,
    input  logic [DATA_W-1:0] ic_inst,
    input  logic              bp_taken,
    input  logic [DATA_W-1:0] bp_target,
    input  logic              dcache_stall,
    input  logic              IF_ID_Write,
    input  logic              predict_fail,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              icache_stall,
    output logic [DATA_W-1:0] inst_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              predict_out,
    output logic [DATA_W-1:0] predict_pc_out
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              hold;
    logic              req_raw;
    logic              accept_raw;
    logic              accept;
    logic [DATA_W-1:0] live_predict_pc;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_inst, skid_pc, skid_predict_pc;
    logic              skid_predict;

    assign hold            = dcache_stall | IF_ID_Write;
    assign live_predict_pc = bp_taken ? bp_target : '0;
    // Reset must also silence the combinational request/accept paths, not just the registers.
    assign ic_req          = req_raw & rst_n;
    assign accept          = accept_raw & rst_n;
    assign ic_addr         = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_raw    = 1'b0;
        accept_raw = 1'b0;
        case (state_q)
            FETCH: begin
                // No new request while the skid holds an entry or while redirecting.
                req_raw    = !skid_valid && !predict_fail;
                accept_raw = req_raw && ic_resp;
                if (req_raw && !ic_resp) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                req_raw    = 1'b1;
                accept_raw = ic_resp && !predict_fail;
                if (ic_resp) begin
                    state_d = FETCH;
                end else if (predict_fail) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (ic_resp) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (predict_fail) begin
            pc_d = redirect_pc;
        end else if (accept) begin
            pc_d = bp_taken ? bp_target : pc_q + INST_B;
        end
    end

    inst_fetch_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (accept && hold),
        .pop           (skid_valid && !hold),
        .flush         (predict_fail),
        .in_inst       (ic_inst),
        .in_pc         (pc_q),
        .in_predict    (bp_taken),
        .in_predict_pc (live_predict_pc),
        .valid         (skid_valid),
        .inst          (skid_inst),
        .pc            (skid_pc),
        .predict       (skid_predict),
        .predict_pc    (skid_predict_pc)
    );

    always_comb begin
        icache_stall   = 1'b1;
        inst_out       = '0;
        pc_out         = '0;
        predict_out    = 1'b0;
        predict_pc_out = '0;
        if (predict_fail) begin
            icache_stall = 1'b1;
        end else if (skid_valid) begin
            icache_stall   = 1'b0;
            inst_out       = skid_inst;
            pc_out         = skid_pc;
            predict_out    = skid_predict;
            predict_pc_out = skid_predict_pc;
        end else if (accept) begin
            icache_stall   = 1'b0;
            inst_out       = ic_inst;
            pc_out         = pc_q;
            predict_out    = bp_taken;
            predict_pc_out = live_predict_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational icache/predictor stand-in.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_resp;
    logic [31:0] ic_inst;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        dcache_stall;
    logic        if_id_write;
    logic        predict_fail;
    logic [31:0] redirect_pc;
    logic        icache_stall;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        predict_out;
    logic [31:0] predict_pc_out;

    logic        hit_en;
    logic        stale_pulse;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic [31:0] bp_tgt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // Hit whenever a request is up and hits are enabled; stale_pulse models a late miss return.
    always_comb begin
        ic_resp   = (hit_en & ic_req) | stale_pulse;
        ic_inst   = stale_pulse ? 32'hBAD0_BAD0 : inst_of(ic_addr);
        bp_taken  = bp_en && (ic_addr == bp_pc);
        bp_target = bp_tgt;
    end

    inst_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_resp        (ic_resp),
        .ic_inst        (ic_inst),
        .bp_taken       (bp_taken),
        .bp_target      (bp_target),
        .dcache_stall   (dcache_stall),
        .IF_ID_Write    (if_id_write),
        .predict_fail   (predict_fail),
        .redirect_pc    (redirect_pc),
        .icache_stall   (icache_stall),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .predict_out    (predict_out),
        .predict_pc_out (predict_pc_out)
    );

    task automatic test_reset();
        rst_n = 1'b0; hit_en = 1'b1; stale_pulse = 1'b0; bp_en = 1'b0;
        bp_pc = 32'h0; bp_tgt = 32'h7777_0000; dcache_stall = 1'b0;
        if_id_write = 1'b0; predict_fail = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ic_req !== 1'b0) begin failures++; $display("FAIL reset_ic_req got=%b exp=0", ic_req); end
        checks++; if (icache_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", icache_stall); end
        checks++; if (pc_out !== 32'h0 || inst_out !== 32'h0) begin failures++; $display("FAIL reset_data pc=%h inst=%h exp=0", pc_out, inst_out); end
        checks++; if (ic_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ic_addr); end
    endtask

    task automatic test_hits();
        logic [31:0] exp_pc;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_pc = 32'(i * 4);
            checks++; if (icache_stall !== 1'b0) begin failures++; $display("FAIL hit_stall[%0d] got=%b exp=0", i, icache_stall); end
            checks++; if (pc_out !== exp_pc || inst_out !== inst_of(exp_pc)) begin failures++; $display("FAIL hit_data[%0d] pc=%h inst=%h exp_pc=%h", i, pc_out, inst_out, exp_pc); end
            checks++; if (predict_out !== 1'b0 || predict_pc_out !== 32'h0) begin failures++; $display("FAIL hit_pred[%0d] p=%b ppc=%h exp=0", i, predict_out, predict_pc_out); end
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) hit_en = 1'b0;
            #1;
            checks++; if (ic_addr !== 32'h10 || ic_req !== 1'b1) begin failures++; $display("FAIL miss_addr[%0d] addr=%h req=%b exp=10/1", i, ic_addr, ic_req); end
            checks++; if (icache_stall !== 1'b1) begin failures++; $display("FAIL miss_stall[%0d] got=%b exp=1", i, icache_stall); end
        end
        @(negedge clk) hit_en = 1'b1;
        #1;
        checks++; if (icache_stall !== 1'b0 || pc_out !== 32'h10 || inst_out !== inst_of(32'h10)) begin failures++; $display("FAIL miss_return stall=%b pc=%h inst=%h exp_pc=10", icache_stall, pc_out, inst_out); end
    endtask

    task automatic test_predict();
        bp_en = 1'b1; bp_pc = 32'h18; bp_tgt = 32'h40;
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h14 || predict_out !== 1'b0 || predict_pc_out !== 32'h0) begin failures++; $display("FAIL pred_nt pc=%h p=%b ppc=%h exp=14/0/0", pc_out, predict_out, predict_pc_out); end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h18 || predict_out !== 1'b1 || predict_pc_out !== 32'h40) begin failures++; $display("FAIL pred_taken pc=%h p=%b ppc=%h exp=18/1/40", pc_out, predict_out, predict_pc_out); end
        @(negedge clk) bp_en = 1'b0;
        #1;
        checks++; if (pc_out !== 32'h40 || inst_out !== inst_of(32'h40) || predict_out !== 1'b0) begin failures++; $display("FAIL pred_target pc=%h inst=%h p=%b exp_pc=40", pc_out, inst_out, predict_out); end
    endtask

    task automatic test_hold();
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h44) begin failures++; $display("FAIL hold_pre pc=%h exp=44", pc_out); end
        @(negedge clk) if_id_write = 1'b1;
        #1;
        checks++; if (pc_out !== 32'h48 || icache_stall !== 1'b0) begin failures++; $display("FAIL hold_c0 pc=%h stall=%b exp=48/0", pc_out, icache_stall); end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h48 || inst_out !== inst_of(32'h48) || ic_req !== 1'b0) begin failures++; $display("FAIL hold_c1 pc=%h inst=%h req=%b exp=48/req0", pc_out, inst_out, ic_req); end
        @(negedge clk) if_id_write = 1'b0;
        #1;
        checks++; if (pc_out !== 32'h48 || icache_stall !== 1'b0 || ic_req !== 1'b0) begin failures++; $display("FAIL hold_drain pc=%h stall=%b req=%b exp=48/0/0", pc_out, icache_stall, ic_req); end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h4C || inst_out !== inst_of(32'h4C)) begin failures++; $display("FAIL hold_next pc=%h exp=4c", pc_out); end
        @(negedge clk) dcache_stall = 1'b1;
        #1;
        checks++; if (pc_out !== 32'h50) begin failures++; $display("FAIL dstall_c0 pc=%h exp=50", pc_out); end
        @(negedge clk) dcache_stall = 1'b0;
        #1;
        checks++; if (pc_out !== 32'h50 || inst_out !== inst_of(32'h50) || icache_stall !== 1'b0) begin failures++; $display("FAIL dstall_drain pc=%h stall=%b exp=50/0", pc_out, icache_stall); end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h54) begin failures++; $display("FAIL dstall_next pc=%h exp=54", pc_out); end
    endtask

    task automatic test_redirect();
        @(negedge clk) begin predict_fail = 1'b1; redirect_pc = 32'h20; end
        #1;
        checks++; if (icache_stall !== 1'b1 || pc_out !== 32'h0 || ic_req !== 1'b0) begin failures++; $display("FAIL redir_hit stall=%b pc=%h req=%b exp=1/0/0", icache_stall, pc_out, ic_req); end
        @(negedge clk) begin predict_fail = 1'b0; hit_en = 1'b0; end
        #1;
        checks++; if (ic_addr !== 32'h20 || ic_req !== 1'b1 || icache_stall !== 1'b1) begin failures++; $display("FAIL redir_miss addr=%h req=%b stall=%b exp=20/1/1", ic_addr, ic_req, icache_stall); end
        @(negedge clk) begin predict_fail = 1'b1; redirect_pc = 32'h100; end
        #1;
        checks++; if (icache_stall !== 1'b1 || inst_out !== 32'h0) begin failures++; $display("FAIL redir_wait stall=%b inst=%h exp=1/0", icache_stall, inst_out); end
        @(negedge clk) predict_fail = 1'b0;
        #1;
        checks++; if (ic_req !== 1'b0 || ic_addr !== 32'h100 || icache_stall !== 1'b1) begin failures++; $display("FAIL drop_state req=%b addr=%h stall=%b exp=0/100/1", ic_req, ic_addr, icache_stall); end
        @(negedge clk) stale_pulse = 1'b1;
        #1;
        checks++; if (icache_stall !== 1'b1 || inst_out !== 32'h0 || pc_out !== 32'h0) begin failures++; $display("FAIL drop_stale stall=%b inst=%h pc=%h exp=1/0/0", icache_stall, inst_out, pc_out); end
        @(negedge clk) begin stale_pulse = 1'b0; hit_en = 1'b1; end
        #1;
        checks++; if (icache_stall !== 1'b0 || pc_out !== 32'h100 || inst_out !== inst_of(32'h100)) begin failures++; $display("FAIL redir_resume stall=%b pc=%h exp=0/100", icache_stall, pc_out); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk) hit_en = 1'b0;
        #1;
        checks++; if (ic_addr !== 32'h104 || icache_stall !== 1'b1) begin failures++; $display("FAIL rmid_miss addr=%h stall=%b exp=104/1", ic_addr, icache_stall); end
        @(negedge clk) rst_n = 1'b0;
        #1;
        checks++; if (ic_req !== 1'b0 || ic_addr !== 32'h0 || icache_stall !== 1'b1) begin failures++; $display("FAIL rmid_wait req=%b addr=%h stall=%b exp=0/0/1", ic_req, ic_addr, icache_stall); end
        @(negedge clk) begin rst_n = 1'b1; hit_en = 1'b1; end
        #1;
        checks++; if (pc_out !== 32'h0 || icache_stall !== 1'b0) begin failures++; $display("FAIL rmid_restart pc=%h stall=%b exp=0/0", pc_out, icache_stall); end
        @(negedge clk) if_id_write = 1'b1;
        #1;
        checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL rskid_fill pc=%h exp=4", pc_out); end
        @(negedge clk) begin rst_n = 1'b0; if_id_write = 1'b0; end
        #1;
        checks++; if (icache_stall !== 1'b1 || inst_out !== 32'h0 || pc_out !== 32'h0) begin failures++; $display("FAIL rskid_reset stall=%b inst=%h pc=%h exp=1/0/0", icache_stall, inst_out, pc_out); end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (ic_req !== 1'b1 || pc_out !== 32'h0 || inst_out !== inst_of(32'h0)) begin failures++; $display("FAIL rskid_restart req=%b pc=%h inst=%h exp=1/0", ic_req, pc_out, inst_out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hits();
        test_miss();
        test_predict();
        test_hold();
        test_redirect();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
